// File: rtl/branch_target_adder.sv
// Execute-stage branch-target adder: pc + (imm32 << IMM_SHIFT), registered with
// stall/flush control plus signed-overflow and word-misalignment flags.
module branch_target_adder #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned IMM_SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm32,
  output logic [WIDTH-1:0] pcAddResult,
  output logic             out_valid,
  output logic             overflow,
  output logic             misaligned
);

  logic [WIDTH-1:0] off;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic             mis;

  always_comb begin
    off = imm32 << IMM_SHIFT;
    sum = pc + off;
    // Overflow only when both operands share a sign and the result flips it.
    ovf = (pc[WIDTH-1] == off[WIDTH-1]) && (sum[WIDTH-1] != pc[WIDTH-1]);
    mis = (sum[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcAddResult <= '0;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
      misaligned  <= 1'b0;
    end else if (en) begin
      // Data still tracks sum on a flush so it stays observable; only validity is killed.
      pcAddResult <= sum;
      if (flush) begin
        out_valid  <= 1'b0;
        overflow   <= 1'b0;
        misaligned <= 1'b0;
      end else begin
        out_valid  <= in_valid;
        overflow   <= ovf & in_valid;
        misaligned <= mis & in_valid;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_adder.sv
// Scoreboard bench for branch_target_adder: one instance per IMM_SHIFT (0 and 2)
// driven with the same directed stimulus.
module tb_branch_target_adder;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        v;
    logic        o;
    logic        m;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] imm32 = '0;
  logic [31:0] res0, res2;
  logic        v0, v2, o0, o2, m0, m2;

  int checks = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q2[$];
  exp_t st0, st2;

  always #5 clk = ~clk;

  branch_target_adder #(.WIDTH(32), .IMM_SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
    .pc(pc), .imm32(imm32), .pcAddResult(res0), .out_valid(v0),
    .overflow(o0), .misaligned(m0)
  );

  branch_target_adder #(.WIDTH(32), .IMM_SHIFT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
    .pc(pc), .imm32(imm32), .pcAddResult(res2), .out_valid(v2),
    .overflow(o2), .misaligned(m2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model: 64-bit signed arithmetic decides overflow by range.
  function automatic exp_t model(input exp_t st, input int sh, input string tag);
    exp_t       n;
    logic [31:0] off;
    logic [31:0] s;
    longint     ws;
    bit         ov;
    n = st;
    n.tag = tag;
    if (!en) return n;
    off = imm32 << sh;
    s = pc + off;
    ws = longint'($signed(pc)) + longint'($signed(off));
    ov = (ws > 64'sd2147483647) || (ws < -64'sd2147483648);
    n.res = s;
    if (flush) begin
      n.v = 1'b0; n.o = 1'b0; n.m = 1'b0;
    end else begin
      n.v = in_valid;
      n.o = ov && in_valid;
      n.m = (s % 4 != 0) && in_valid;
    end
    return n;
  endfunction

  task automatic cmp(input string who, input exp_t e, input logic [31:0] r,
                     input logic v, input logic o, input logic m);
    chk({who, ".", e.tag, ".res"}, r, e.res);
    chk({who, ".", e.tag, ".valid"}, {31'b0, v}, {31'b0, e.v});
    chk({who, ".", e.tag, ".ovf"}, {31'b0, o}, {31'b0, e.o});
    chk({who, ".", e.tag, ".mis"}, {31'b0, m}, {31'b0, e.m});
  endtask

  task automatic step(input string tag, input logic e, input logic f, input logic iv,
                      input logic [31:0] p, input logic [31:0] i);
    exp_t x;
    @(negedge clk);
    en = e; flush = f; in_valid = iv; pc = p; imm32 = i;
    st0 = model(st0, 0, tag);
    st2 = model(st2, 2, tag);
    q0.push_back(st0);
    q2.push_back(st2);
    @(posedge clk);
    #1;
    checks++;
    assert (q0.size() == 1 && q2.size() == 1) else begin
      failures++;
      $error("FAIL %s.queue observed=%0d/%0d expected=1/1", tag, q0.size(), q2.size());
    end
    if (q0.size() > 0) begin
      x = q0.pop_front();
      cmp("s0", x, res0, v0, o0, m0);
    end
    if (q2.size() > 0) begin
      x = q2.pop_front();
      cmp("s2", x, res2, v2, o2, m2);
    end
  endtask

  task automatic zero_model();
    st0 = '{tag: "rst", res: 32'h0, v: 1'b0, o: 1'b0, m: 1'b0};
    st2 = st0;
  endtask

  initial begin
    zero_model();
    #1;
    chk("reset.res0", res0, 32'h0);
    chk("reset.flags0", {29'b0, v0, o0, m0}, 32'h0);
    chk("reset.flags2", {29'b0, v2, o2, m2}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    step("basic20", 1, 0, 1, 32'd10, 32'd10);
    chk("basic20.lit", res0, 32'd20);
    for (int k = 0; k < 3; k++) step("stall", 0, 0, 1, 32'h1234_5678, 32'h9);
    chk("stall.lit", {res0[30:0], v0}, {31'd20, 1'b1});
    step("basic30", 1, 0, 1, 32'd10, 32'd20);
    chk("basic30.mis", {31'b0, m0}, 32'd1);
    step("flush", 1, 1, 1, 32'h7FFF_FFFC, 32'd8);
    step("valid_again", 1, 0, 1, 32'h100, 32'h4);
    step("stall_flush", 0, 1, 1, 32'h200, 32'h8);
    step("back_branch", 1, 0, 1, 32'h0040_0004, 32'hFFFF_FFFF);
    chk("back_branch.lit2", res2, 32'h0040_0000);
    step("fwd_word", 1, 0, 1, 32'h0040_0004, 32'd3);
    chk("fwd_word.lit2", res2, 32'h0040_0010);
    step("ovf", 1, 0, 1, 32'h7FFF_FFFC, 32'd8);
    chk("ovf.lit", {res0[31:1], o0}, {31'h4000_0002, 1'b1});
    step("wrap", 1, 0, 1, 32'hFFFF_FFFC, 32'd8);
    chk("wrap.lit", {res0[31:1], o0}, {31'h0000_0002, 1'b0});
    step("ovf_invalid", 1, 0, 0, 32'h7FFF_FFFC, 32'd8);
    step("neg_ovf", 1, 0, 1, 32'h8000_0000, 32'hFFFF_FFFC);

    // Asynchronous reset between edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset.res0", res0, 32'h0);
    chk("midreset.res2", res2, 32'h0);
    chk("midreset.flags", {26'b0, v0, o0, m0, v2, o2, m2}, 32'h0);
    zero_model();
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset", 1, 0, 1, 32'd4, 32'd4);
    chk("post_reset.lit", {res0[30:0], v0}, {31'd8, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_target_adder.md
Name: branch_target_adder

Overview:
- Execute-stage branch-target adder for the MIPS datapath.
- Adds the branch PC to the sign-extended offset, shifted left by a parameterised amount, and registers the target for the next stage.
- Also flags signed overflow and word misalignment of the target.
- Single clock; one-cycle latency with stall and flush control.

Parameters:
- WIDTH, 32, datapath width of pc, imm32 and pcAddResult.
- IMM_SHIFT, 0, left-shift applied to imm32 before the add.
  - 0: imm32 is already a byte offset.
  - 2: imm32 is a word offset (classic MIPS).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  stage enable; 0 = stall (hold all outputs).
- flush  input  1  synchronous kill of the result being captured.
- in_valid  input  1  pc/imm32 carry a real branch this cycle.
- pc  input  WIDTH  branch base address (PC+4 supplied by fetch logic).
- imm32  input  WIDTH  sign-extended branch offset.
- pcAddResult  output  WIDTH  registered branch target.
- out_valid  output  1  pcAddResult holds a valid target.
- overflow  output  1  signed overflow of the target add.
- misaligned  output  1  target bits [1:0] != 0.

Behaviour:
Reset:
- rst_n low asynchronously forces pcAddResult=0, out_valid=0, overflow=0, misaligned=0.
- Release is taken on the next rising edge.

Datapath (combinational, before the register):
- off = imm32 << IMM_SHIFT, truncated to WIDTH. Bits shifted out are discarded; zeros enter at the LSB.
- sum = (pc + off) mod 2^WIDTH. Wrap-around is silent in sum.
- ovf = (pc[MSB] == off[MSB]) && (sum[MSB] != pc[MSB]).
- mis = (sum[1:0] != 0).

Register update, rising clk with rst_n high:
- en=0: all outputs hold, including under flush. Stall has priority over flush.
- en=1, flush=1:
  - out_valid <= 0.
  - pcAddResult <= sum. The data still updates so it is observable, but is not valid.
  - overflow <= 0, misaligned <= 0.
- en=1, flush=0:
  - pcAddResult <= sum, out_valid <= in_valid.
  - overflow <= ovf & in_valid.
  - misaligned <= mis & in_valid.

Timing and flag rules:
- Latency: inputs sampled at edge N appear at outputs after edge N; throughput is one per cycle.
- Flags are qualified by in_valid, so they are never 1 while out_valid=0.
- Reset mid-operation clears all state immediately, with no wait for clk.
- No combinational path from any input to any output.

Arithmetic edge cases:
- pc=0xFFFFFFFC, off=8 gives 0x00000004, overflow=0 (unsigned wrap only).
- pc=0x7FFFFFFC, off=8 gives 0x80000004, overflow=1.
- Negative offsets (imm32 MSB=1) implement backward branches via two's-complement add.

Test Plan:
- Basic add, IMM_SHIFT=0:
  - pc=10, imm32=10, in_valid=1, en=1 -> next edge pcAddResult=20, out_valid=1, misaligned=0.
  - then pc=10, imm32=20 -> pcAddResult=30, misaligned=1.
- IMM_SHIFT=2 (second instance):
  - pc=0x00400004, imm32=0xFFFFFFFF -> pcAddResult=0x00400000, overflow=0, misaligned=0.
  - pc=0x00400004, imm32=3 -> pcAddResult=0x00400010.
- Overflow and wrap:
  - pc=0x7FFFFFFC, imm32=8 -> pcAddResult=0x80000004, overflow=1.
  - pc=0xFFFFFFFC, imm32=8 -> pcAddResult=0x00000004, overflow=0.
- Stall and flush:
  - After the 20 result, en=0 with new inputs -> outputs hold 20/valid for every stalled cycle.
  - en=1, flush=1 -> out_valid=0, overflow=0.
  - en=0, flush=1 -> outputs unchanged.
- Reset:
  - rst_n low between clock edges -> pcAddResult=0 and all flags 0 immediately.
  - First edge after release with in_valid=1, pc=4, imm32=4 -> pcAddResult=8, out_valid=1.
- in_valid=0 with overflowing operands -> pcAddResult updates, out_valid=0, overflow=0.
